// File: rtl/german_rule_scheduler_pkg.sv
// Shared types and constants for the German-protocol rule scheduler.
package german_sched_pkg;

  localparam int unsigned NUM_RULES = 24;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned STEP_W    = 16;
  localparam int unsigned DL_LIMIT  = 4;
  localparam int unsigned DL_W      = $clog2(DL_LIMIT + 1);

  // Out-of-range index that the system model treats as a no-op.
  localparam logic [IDX_W-1:0] IDLE_IDX = IDX_W'(31);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StRun      = 3'd1,
    StPause    = 3'd2,
    StDone     = 3'd3,
    StDeadlock = 3'd4
  } sched_state_e;

  // ModeRsvd selects like round-robin.
  typedef enum logic [1:0] {
    ModeRr    = 2'd0,
    ModePrio  = 2'd1,
    ModeForce = 2'd2,
    ModeRsvd  = 2'd3
  } sched_mode_e;

endpackage

// File: rtl/german_rule_scheduler_if.sv
// Control/status bundle between the guard logic, the scheduler and its driver.
interface german_rule_scheduler_if;
  import german_sched_pkg::*;

  logic [NUM_RULES-1:0] guard_i;
  logic [1:0]           mode_i;
  logic [IDX_W-1:0]     force_idx_i;
  logic                 start_i;
  logic                 pause_i;
  logic [STEP_W-1:0]    budget_i;
  logic [IDX_W-1:0]     en_a_o;
  logic                 fire_o;
  logic [STEP_W-1:0]    steps_o;
  logic [2:0]           state_o;
  logic                 done_o;
  logic                 deadlock_o;

  modport master (
    output guard_i, mode_i, force_idx_i, start_i, pause_i, budget_i,
    input  en_a_o, fire_o, steps_o, state_o, done_o, deadlock_o
  );

  modport slave (
    input  guard_i, mode_i, force_idx_i, start_i, pause_i, budget_i,
    output en_a_o, fire_o, steps_o, state_o, done_o, deadlock_o
  );

endinterface

// File: rtl/german_rule_scheduler_rr_pick.sv
// Rotating priority picker: first set request at index >= ptr_i, wrapping to 0.
module rr_pick #(
  parameter int unsigned NumReq = 24,
  parameter int unsigned IdxW   = 5
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [IdxW-1:0]   idx_o,
  output logic              found_o
);

  int unsigned cand;

  // Scan from the pointer; the first hit wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = 32'(ptr_i) + i;
      if (cand >= NumReq) cand = cand - NumReq;
      if (!found_o && cand < NumReq && req_i[cand[IdxW-1:0]]) begin
        found_o = 1'b1;
        idx_o   = cand[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/german_rule_scheduler.sv
// Picks one enabled protocol rule per cycle for the German `system` model,
// counts fired steps, stops on a step budget and flags deadlock.
module german_rule_scheduler
  import german_sched_pkg::*;
(
  input logic                    clock,
  input logic                    reset,
  german_rule_scheduler_if.slave bus
);

  sched_state_e      state_q, state_d;
  logic [IDX_W-1:0]  en_a_q, en_a_d;
  logic              fire_q, fire_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [STEP_W-1:0] budget_q, budget_d;
  logic              done_q, done_d;
  logic              deadlock_q, deadlock_d;
  logic [DL_W-1:0]   dl_cnt_q, dl_cnt_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;

  logic [IDX_W-1:0]  rr_idx, prio_idx, sel_idx;
  logic              rr_found, prio_found, force_ok, sel_found, rr_mode;

  rr_pick #(
    .NumReq (NUM_RULES),
    .IdxW   (IDX_W)
  ) u_rr_pick (
    .req_i   (bus.guard_i),
    .ptr_i   (ptr_q),
    .idx_o   (rr_idx),
    .found_o (rr_found)
  );

  // Fixed priority is the rotating picker pinned at index 0.
  rr_pick #(
    .NumReq (NUM_RULES),
    .IdxW   (IDX_W)
  ) u_prio_pick (
    .req_i   (bus.guard_i),
    .ptr_i   ('0),
    .idx_o   (prio_idx),
    .found_o (prio_found)
  );

  // Mode mux: choose the winner and whether anything fires.
  always_comb begin
    rr_mode   = 1'b0;
    force_ok  = 1'b0;
    sel_idx   = IDLE_IDX;
    sel_found = 1'b0;
    if (bus.force_idx_i < IDX_W'(NUM_RULES)) force_ok = bus.guard_i[bus.force_idx_i];
    unique case (sched_mode_e'(bus.mode_i))
      ModePrio: begin
        sel_idx   = prio_idx;
        sel_found = prio_found;
      end
      ModeForce: begin
        sel_idx   = bus.force_idx_i;
        sel_found = force_ok;
      end
      default: begin
        rr_mode   = 1'b1;
        sel_idx   = rr_idx;
        sel_found = rr_found;
      end
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    en_a_d     = IDLE_IDX;
    fire_d     = 1'b0;
    steps_d    = steps_q;
    budget_d   = budget_q;
    done_d     = done_q;
    deadlock_d = deadlock_q;
    dl_cnt_d   = dl_cnt_q;
    ptr_d      = ptr_q;
    unique case (state_q)
      StIdle, StDone, StDeadlock: begin
        if (bus.start_i) begin
          state_d    = StRun;
          steps_d    = '0;
          done_d     = 1'b0;
          deadlock_d = 1'b0;
          dl_cnt_d   = '0;
          budget_d   = bus.budget_i;
        end
      end
      StRun: begin
        if (bus.pause_i) begin
          state_d = StPause;
        end else if (sel_found) begin
          en_a_d   = sel_idx;
          fire_d   = 1'b1;
          dl_cnt_d = '0;
          steps_d  = (steps_q == '1) ? steps_q : steps_q + STEP_W'(1);
          if (rr_mode) begin
            ptr_d = (rr_idx == IDX_W'(NUM_RULES - 1)) ? '0 : rr_idx + IDX_W'(1);
          end
          // The final fire still issues; done rises alongside it.
          if (budget_q != '0 && steps_d == budget_q) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end else begin
          dl_cnt_d = dl_cnt_q + DL_W'(1);
          if (dl_cnt_d == DL_W'(DL_LIMIT)) begin
            state_d    = StDeadlock;
            deadlock_d = 1'b1;
          end
        end
      end
      StPause: begin
        if (!bus.pause_i) state_d = StRun;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= StIdle;
      en_a_q     <= IDLE_IDX;
      fire_q     <= 1'b0;
      steps_q    <= '0;
      budget_q   <= '0;
      done_q     <= 1'b0;
      deadlock_q <= 1'b0;
      dl_cnt_q   <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      en_a_q     <= en_a_d;
      fire_q     <= fire_d;
      steps_q    <= steps_d;
      budget_q   <= budget_d;
      done_q     <= done_d;
      deadlock_q <= deadlock_d;
      dl_cnt_q   <= dl_cnt_d;
      ptr_q      <= ptr_d;
    end
  end

  assign bus.en_a_o     = en_a_q;
  assign bus.fire_o     = fire_q;
  assign bus.steps_o    = steps_q;
  assign bus.state_o    = state_q;
  assign bus.done_o     = done_q;
  assign bus.deadlock_o = deadlock_q;

endmodule

// File: doc/german_rule_scheduler.md
Name: german_rule_scheduler

Overview:
- Sequencer that drives the rule-select input `io_en_a` of the German-protocol `system` model.
- Each cycle it chooses one rule whose guard is true (round-robin, fixed-priority or forced index) and counts fired steps.
- Detects deadlock (no enabled guard) and stops after a programmable step budget.
- Sits between the guard-evaluation logic and `system`, replacing free-running stimulus in equivalence and trace runs.

Parameters:
- NUM_RULES, 24, number of protocol rules; rule indices 0..NUM_RULES-1.
- IDX_W, 5, width of the rule index; must satisfy 2^IDX_W > NUM_RULES.
- IDLE_IDX, 31, index driven when no rule fires; must be ≥ NUM_RULES (the model treats it as a no-op).
- STEP_W, 16, width of the step counter and budget.
- DL_LIMIT, 4, consecutive no-guard cycles in RUN that declare deadlock.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clock).
- guard_i  input  NUM_RULES  bit r = guard of rule r is true this cycle.
- mode_i  input  2  0 = round-robin, 1 = fixed priority (lowest index wins), 2 = forced, 3 = reserved (behaves as 0).
- force_idx_i  input  IDX_W  rule to fire in forced mode.
- start_i  input  1  single-cycle pulse: IDLE/DONE/DEADLOCK → RUN.
- pause_i  input  1  level: hold in PAUSE while high.
- budget_i  input  STEP_W  steps to execute; 0 = unlimited.
- en_a_o  output  IDX_W  rule index to `system` `io_en_a`.
- fire_o  output  1  en_a_o is a valid rule this cycle.
- steps_o  output  STEP_W  rules fired since last start.
- state_o  output  3  FSM state encoding.
- done_o  output  1  budget reached (sticky until start).
- deadlock_o  output  1  deadlock flagged (sticky until start).

Behaviour:
- Reset (reset == 0 at clock edge):
  - State IDLE; en_a_o = IDLE_IDX; fire_o = 0.
  - steps_o = 0; done_o = 0; deadlock_o = 0.
  - Round-robin pointer = 0; deadlock counter = 0.
  - Reset mid-RUN aborts immediately; no partial step is counted.
- States: IDLE = 0, RUN = 1, PAUSE = 2, DONE = 3, DEADLOCK = 4.
- IDLE/DONE/DEADLOCK, start_i = 1:
  - Next state RUN.
  - Clear steps, done, deadlock and the deadlock counter.
  - Latch budget_i into an internal register; later changes to budget_i are ignored until the next start.
  - Round-robin pointer is retained.
- Selection is combinational from guard_i, mode_i, the RR pointer and force_idx_i. en_a_o and fire_o are registered, so a selection appears one cycle after the guards are sampled.
  - Round-robin: first set guard at index ≥ pointer, wrapping to 0. On fire, pointer ← winner+1, wrapping NUM_RULES-1 → 0.
  - Fixed priority: lowest set guard index; pointer unchanged.
  - Forced: fires force_idx_i only if force_idx_i < NUM_RULES and its guard is set; otherwise no fire.
- RUN, a rule selected:
  - Next cycle en_a_o = winner, fire_o = 1, steps +1, deadlock counter cleared.
  - steps_o saturates at all-ones.
- RUN, nothing selected:
  - en_a_o = IDLE_IDX, fire_o = 0, deadlock counter +1.
  - When the counter reaches DL_LIMIT: state DEADLOCK, deadlock_o = 1.
  - In forced mode a non-firing cycle also counts toward deadlock.
- Budget:
  - When a fire makes steps equal a nonzero latched budget, that fire still issues; next state DONE and done_o = 1 in the same cycle as that fire_o.
  - A zero budget never terminates.
- PAUSE:
  - Entered from RUN when pause_i = 1; the next cycle drives IDLE_IDX with fire_o = 0.
  - Counters are frozen; deadlock does not advance.
  - pause_i = 0 returns to RUN.
- Simultaneous events, highest priority first:
  - start_i in RUN or PAUSE is ignored.
  - pause_i has priority over selection.
  - Deadlock and budget completion in the same cycle cannot occur, because a fire clears the deadlock counter.
- Outside RUN, en_a_o = IDLE_IDX and fire_o = 0 in every cycle.

Decomposition:
- Package `german_sched_pkg`:
  - state enum;
  - mode constants (RR, PRIO, FORCE);
  - IDLE_IDX;
  - index and step widths.
- One sub-module `rr_pick`: parameterised rotating priority picker (NUM_RULES request vector + pointer → winner index + found flag). Fixed priority reuses it with pointer = 0.

Test Plan:
- Round-robin, guard_i = 0b101 (rules 0 and 2), budget 4, start → en_a_o sequence 0, 2, 0, 2 with fire_o = 1; done_o = 1 on the 4th fire; state DONE; steps_o = 4.
- Fixed priority, guard_i = 0b1100 → en_a_o = 2 every cycle; pointer unchanged. Then switch to RR mode with guards unchanged → first fire is 2 (pointer 0, guards {2,3}), then 3.
- Forced, force_idx_i = 5, guard bit 5 = 0, DL_LIMIT = 4 → four cycles of en_a_o = 31, fire_o = 0, then deadlock_o = 1 and state DEADLOCK. A following start → RUN with deadlock_o cleared.
- Pause: RUN at steps_o = 3, pause_i high for 5 cycles with all guards set → fire_o = 0 and steps_o stays 3. Release → firing resumes from the saved RR pointer.
- Reset: reset = 0 during RUN at steps_o = 7 → next edge IDLE, steps_o = 0, en_a_o = 31, fire_o = 0, done_o = deadlock_o = 0. Also: start_i asserted while reset = 0 has no effect.
- Wrap and budget-0: NUM_RULES = 24, only guard 23 and guard 0 set, pointer at 23 → sequence 23, 0, 23. With budget 0, run 70000 fires → steps_o saturates at 65535 and state remains RUN.
